// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding and header marker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: state_e (IDLE/FETCH/SEND, plus HDR when UART_CHID_HDR_EN is defined),
//           HDR_MARK (upper nibble of the channel-id header byte), CNT_W (burst counter width).
package uart_pkg;

  // Marker placed in the upper nibble of the channel-id header byte.
  localparam logic [3:0] HDR_MARK = 4'hA;

  // Burst counter width; BURST_LEN is limited to 255.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
`ifdef UART_CHID_HDR_EN
    ,
    ST_HDR   = 2'd3
`endif
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner search: first asserted request strictly after last_grant, with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the winner.
// Ports: req (request vector), last_grant (previous winner),
//        any (some request asserted), winner (index of the chosen request).
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int GW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic             any,
  output logic [GW-1:0]    winner
);

  int          idx;
  logic [GW-1:0] sel;

  // Walk the offsets from farthest to nearest so the nearest asserted
  // request after last_grant is the one left standing.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    sel    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % N_REQ;
      sel = GW'(idx);
      if (req[sel]) begin
        any    = 1'b1;
        winner = sel;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding bursts of up to BURST_LEN bytes from N_REQ requesters into one UART.
// Latency: req_vld seen in IDLE (cycle 0) -> req_rdy (cycle 1) -> uart_din_vld (cycle 2).
// Backpressure: a byte is held on uart_din with uart_din_vld high until uart_rfd; requesters wait.
// Optional feature: define UART_CHID_HDR_EN to send a header byte {4'hA, grant_id} at the start
// of every grant (the header does not count toward the burst length).
// Ports: clk, rst (sync, active-high); req_vld/req_data/req_rdy (per-requester byte handshake,
//        requester i on req_data[i*DI_WIDTH +: DI_WIDTH]); uart_rfd/uart_din/uart_din_vld (UART side);
//        grant_id (current grant); busy (FSM not in IDLE).
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DI_WIDTH  = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_vld,
  input  logic [N_REQ*DI_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]          req_rdy,
  input  logic                      uart_rfd,
  output logic [DI_WIDTH-1:0]       uart_din,
  output logic                      uart_din_vld,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy
);

  localparam int GW = $clog2(N_REQ);

  state_e           state;
  logic [GW-1:0]    last_grant;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W:0]   cnt_next;
  logic             arb_any;
  logic [GW-1:0]    arb_winner;
  logic             fetch_ok;
  logic [DI_WIDTH-1:0] fetch_byte;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_arb (
    .req        (req_vld),
    .last_grant (last_grant),
    .any        (arb_any),
    .winner     (arb_winner)
  );

  assign fetch_ok   = (state == ST_FETCH) && req_vld[grant_id];
  assign fetch_byte = req_data[grant_id*DI_WIDTH +: DI_WIDTH];
  assign cnt_next   = {1'b0, burst_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign busy       = (state != ST_IDLE);

  // req_rdy is derived from the live req_vld so it can never pulse for a
  // requester that has withdrawn; it is also masked during reset so an
  // interrupted FETCH never completes a handshake the FSM will not honour.
  always_comb begin
    req_rdy = '0;
    if (fetch_ok && !rst) begin
      req_rdy[grant_id] = 1'b1;
    end
  end

`ifdef UART_CHID_HDR_EN
  logic [DI_WIDTH-1:0] hdr_byte;
  assign hdr_byte = {HDR_MARK, (DI_WIDTH-4)'(arb_winner)};
`endif

  // uart_din doubles as the holding register: it is loaded on the FETCH
  // handshake and cleared on every transfer, so it reads 0 whenever
  // uart_din_vld is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      uart_din_vld <= 1'b0;
      uart_din     <= '0;
      grant_id     <= '0;
      burst_cnt    <= '0;
      last_grant   <= GW'(N_REQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            grant_id  <= arb_winner;
            burst_cnt <= '0;
`ifdef UART_CHID_HDR_EN
            state        <= ST_HDR;
            uart_din_vld <= 1'b1;
            uart_din     <= hdr_byte;
`else
            state        <= ST_FETCH;
`endif
          end
        end
`ifdef UART_CHID_HDR_EN
        ST_HDR: begin
          if (uart_rfd) begin
            uart_din_vld <= 1'b0;
            uart_din     <= '0;
            state        <= ST_FETCH;
          end
        end
`endif
        ST_FETCH: begin
          if (fetch_ok) begin
            uart_din     <= fetch_byte;
            uart_din_vld <= 1'b1;
            state        <= ST_SEND;
          end else begin
            // Requester withdrew: the grant ends here.
            last_grant <= grant_id;
            state      <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (uart_rfd) begin
            uart_din_vld <= 1'b0;
            uart_din     <= '0;
            burst_cnt    <= cnt_next[CNT_W-1:0];
            if (cnt_next < (CNT_W+1)'(BURST_LEN)) begin
              state <= ST_FETCH;
            end else begin
              last_grant <= grant_id;
              state      <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched (N_REQ=4, DI_WIDTH=8, BURST_LEN=2).
// Requesters are byte queues; the expected UART stream is predicted from the queue contents
// with a round-robin/burst model and compared transfer by transfer, alongside protocol invariants.
module tb_uart_tx_sched;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_vld;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_rdy;
  logic            uart_rfd;
  logic [DW-1:0]   uart_din;
  logic            uart_din_vld;
  logic [1:0]      grant_id;
  logic            busy;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .N_REQ     (N),
    .DI_WIDTH  (DW),
    .BURST_LEN (BL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_vld      (req_vld),
    .req_data     (req_data),
    .req_rdy      (req_rdy),
    .uart_rfd     (uart_rfd),
    .uart_din     (uart_din),
    .uart_din_vld (uart_din_vld),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [N][16];
  int         len  [N];
  int         head [N];
  int         rdy_pulses [N];
  logic [7:0] exp_b [$];
  int         exp_g [$];
  int         model_last;
  int         rfd_mode;      // 0 random, 1 always high, 2 always low
  int         xfers;
  logic       prev_xfer, prev_stall;
  logic [7:0] prev_din;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_vld[i] = (head[i] < len[i]);
      if (head[i] < len[i]) req_data[i*DW +: DW] = mem[i][head[i]];
      else                  req_data[i*DW +: DW] = 8'h00;
    end
    case (rfd_mode)
      0:       uart_rfd = ($urandom_range(0, 2) != 0);
      1:       uart_rfd = 1'b1;
      default: uart_rfd = 1'b0;
    endcase
  endtask

  // Predict the whole UART stream: pick the next non-empty queue after the
  // previous grant, take up to BL bytes from it, repeat until all are empty.
  task automatic build_expected();
    int rem [N];
    int pos [N];
    int g, c, take;
    bit found;
    exp_b.delete();
    exp_g.delete();
    for (int i = 0; i < N; i++) begin
      rem[i] = len[i] - head[i];
      pos[i] = head[i];
    end
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      g = 0;
      for (int k = 1; k <= N; k++) begin
        c = (model_last + k) % N;
        if (!found && rem[c] > 0) begin
          found = 1'b1;
          g = c;
        end
      end
      if (found) begin
`ifdef UART_CHID_HDR_EN
        exp_b.push_back({4'hA, 4'(g)});
        exp_g.push_back(g);
`endif
        take = (rem[g] < BL) ? rem[g] : BL;
        for (int t = 0; t < take; t++) begin
          exp_b.push_back(mem[g][pos[g]]);
          exp_g.push_back(g);
          pos[g]++;
        end
        rem[g] -= take;
        model_last = g;
      end
    end
  endtask

  task automatic mon();
    @(negedge clk);
    check("rdy_onehot", 32'($countones(req_rdy) <= 1), 32'd1);
    check("rdy_without_vld", 32'(req_rdy & ~req_vld), 32'd0);
    if (!uart_din_vld) check("din_idle_zero", 32'(uart_din), 32'd0);
    if (prev_xfer) check("vld_gap_after_xfer", 32'(uart_din_vld), 32'd0);
    if (prev_stall) check("stall_hold", 32'({uart_din_vld, uart_din}), 32'({1'b1, prev_din}));
    if (uart_din_vld || req_rdy != '0) check("busy_active", 32'(busy), 32'd1);
    if (uart_din_vld && uart_rfd) begin
      xfers++;
      check("xfer_expected", 32'(exp_b.size() != 0), 32'd1);
      if (exp_b.size() != 0) begin
        check("xfer_byte", 32'(uart_din), 32'(exp_b[0]));
        check("xfer_grant", 32'(grant_id), 32'(exp_g[0]));
        void'(exp_b.pop_front());
        void'(exp_g.pop_front());
      end
    end
    prev_xfer  = uart_din_vld && uart_rfd;
    prev_stall = uart_din_vld && !uart_rfd;
    prev_din   = uart_din;
    for (int i = 0; i < N; i++) begin
      if (req_rdy[i] && req_vld[i]) begin
        rdy_pulses[i]++;
        head[i]++;
      end
    end
  endtask

  task automatic cyc();
    mon();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((exp_b.size() != 0 || busy) && n < budget) begin
      cyc();
      n++;
    end
    check("run_within_budget", 32'(n < budget), 32'd1);
    check("expected_consumed", 32'(exp_b.size()), 32'd0);
    for (int i = 0; i < N; i++) check("queue_drained", 32'(head[i]), 32'(len[i]));
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_vld"},  32'(uart_din_vld), 32'd0);
    check({tag, "_din"},  32'(uart_din),     32'd0);
    check({tag, "_rdy"},  32'(req_rdy),      32'd0);
    check({tag, "_busy"}, 32'(busy),         32'd0);
    check({tag, "_gid"},  32'(grant_id),     32'd0);
  endtask

  // One-cycle reset pulse; req_rdy must stay low while rst is high.
  task automatic rst_pulse();
    rst = 1'b1;
    @(negedge clk);
    check("rst_no_rdy", 32'(req_rdy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("post_rst");
    prev_xfer  = 1'b0;
    prev_stall = 1'b0;
    model_last = N - 1;
    exp_b.delete();
    exp_g.delete();
  endtask

  task automatic clear_q();
    for (int i = 0; i < N; i++) begin
      len[i] = 0;
      head[i] = 0;
      rdy_pulses[i] = 0;
    end
  endtask

  task automatic load_rand(input int i, input int n);
    for (int t = 0; t < n; t++) mem[i][t] = 8'($urandom);
    len[i]  = n;
    head[i] = 0;
  endtask

  initial begin
    int cnt, x0, n_exp;
    rst = 1'b1;
    req_vld = '0;
    req_data = '0;
    uart_rfd = 1'b0;
    rfd_mode = 0;
    xfers = 0;
    prev_xfer = 1'b0;
    prev_stall = 1'b0;
    prev_din = '0;
    model_last = N - 1;
    clear_q();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    drive();

    // Single requester 2 with 0x11/0x22/0x33, rfd high; also first-grant latency.
    clear_q();
    mem[2][0] = 8'h11; mem[2][1] = 8'h22; mem[2][2] = 8'h33; len[2] = 3;
    rfd_mode = 1;
    build_expected();
    drive();
    cyc();
`ifdef UART_CHID_HDR_EN
    check("lat_hdr_vld", 32'(uart_din_vld), 32'd1);
    check("lat_hdr_din", 32'(uart_din), 32'hA2);
`else
    check("lat_rdy_cycle1", 32'(req_rdy), 32'b0100);
    cyc();
    check("lat_vld_cycle2", 32'(uart_din_vld), 32'd1);
    check("lat_din_cycle2", 32'(uart_din), 32'h11);
`endif
    run(200);
    check("req2_rdy_pulses", 32'(rdy_pulses[2]), 32'd3);

    // Fairness: all four requesters valid from reset, random rfd.
    clear_q();
    for (int i = 0; i < N; i++) load_rand(i, 4);
    rst_pulse();
    rfd_mode = 0;
    build_expected();
    drive();
    run(600);

    // Abort: requester 1 has one byte only, requester 3 follows.
    clear_q();
    load_rand(1, 1);
    load_rand(3, 3);
    build_expected();
    drive();
    run(300);

    // Backpressure: rfd low for 50 cycles while a byte (0x5A) is offered.
    clear_q();
    mem[0][0] = 8'h5A; len[0] = 1;
    rfd_mode = 2;
    build_expected();
    drive();
    cnt = 0;
    while (!uart_din_vld && cnt < 10) begin cyc(); cnt++; end
    check("bp_reach_send", 32'(uart_din_vld), 32'd1);
    cnt = 0;
    repeat (50) begin
      cyc();
      if (uart_din_vld === 1'b1 && exp_b.size() != 0 && uart_din === exp_b[0]) cnt++;
    end
    check("bp_hold_cycles", 32'(cnt), 32'd50);
    x0 = xfers;
    n_exp = exp_b.size();
    rfd_mode = 1;
    drive();
    run(100);
    check("bp_xfer_count", 32'(xfers - x0), 32'(n_exp));

    // Reset while a requester sees req_rdy in FETCH: no handshake may complete.
    clear_q();
    load_rand(0, 4);
    load_rand(2, 2);
    rfd_mode = 1;
    build_expected();
    drive();
    cnt = 0;
    while (req_rdy == '0 && cnt < 10) begin cyc(); cnt++; end
    check("fetch_reach", 32'(req_rdy != '0), 32'd1);
    rst_pulse();
    check("no_pop_on_rst", 32'(head[0] + head[2]), 32'd0);
    build_expected();
    drive();
    run(300);

    // Reset mid-SEND during requester 1's burst; requester 0 then wins first.
    clear_q();
    load_rand(1, 4);
    load_rand(2, 3);
    rfd_mode = 2;
    build_expected();
    drive();
    cnt = 0;
    while (!uart_din_vld && cnt < 10) begin cyc(); cnt++; end
    check("send_reach", 32'(uart_din_vld), 32'd1);
    rst_pulse();
    load_rand(0, 2);
    rfd_mode = 0;
    build_expected();
    drive();
    run(400);

    // Random queue mixes chained without reset.
    for (int it = 0; it < 8; it++) begin
      clear_q();
      for (int i = 0; i < N; i++) load_rand(i, $urandom_range(0, 5));
      rfd_mode = 0;
      build_expected();
      drive();
      run(500);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters (2..16).
REQ-002 The block SHALL have parameter DI_WIDTH, default 8, byte width; equal to the UART DI_WIDTH.
REQ-003 The block SHALL have parameter BURST_LEN, default 4, max bytes per grant (1..255).
REQ-004 The block SHALL have port clk  in  1  single clock for all logic.
REQ-005 The block SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port req_vld  in  N_REQ  per-requester byte-valid.
REQ-007 The block SHALL have port req_data  in  N_REQ*DI_WIDTH  packed bytes; requester i occupies bits [i*DI_WIDTH +: DI_WIDTH].
REQ-008 The block SHALL have port req_rdy  out  N_REQ  one-hot byte-accept pulse.
REQ-009 The block SHALL have port uart_rfd  in  1  UART request-for-data.
REQ-010 The block SHALL have port uart_din  out  DI_WIDTH  byte to the UART.
REQ-011 The block SHALL have port uart_din_vld  out  1  byte valid to the UART.
REQ-012 The block SHALL have port grant_id  out  clog2(N_REQ)  currently granted requester.
REQ-013 The block SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, HDR, FETCH and SEND.
REQ-015 In IDLE with any req_vld high, the block SHALL grant round-robin, searching from last_grant+1 upward with wrap, load grant_id, clear burst_cnt, and go to HDR (macro defined) or FETCH.
REQ-016 In FETCH, if req_vld[grant_id]=1, the block SHALL assert req_rdy[grant_id] for exactly one cycle, capture the byte into the holding register, and go to SEND; otherwise it SHALL go to IDLE without pulsing.
REQ-017 A UART transfer SHALL occur on any cycle with uart_din_vld=1 and uart_rfd=1.
REQ-018 In SEND, uart_din_vld SHALL stay high with uart_din stable until the transfer occurs.
REQ-019 On a SEND transfer, the block SHALL increment burst_cnt, then go to FETCH if burst_cnt < BURST_LEN, else to IDLE.
REQ-020 uart_din_vld SHALL be low for at least one cycle after every transfer.
REQ-021 last_grant SHALL update to grant_id whenever the FSM enters IDLE from a granted state.
REQ-022 At most one req_rdy bit SHALL be high in any cycle, and req_rdy SHALL never pulse while req_vld for that requester is low.
REQ-023 Latency SHALL be: req_vld seen in IDLE at cycle 0 -> req_rdy at cycle 1 -> uart_din_vld at cycle 2 (macro undefined).
REQ-024 A requester dropping req_vld mid-burst SHALL end the grant at the next FETCH.
REQ-025 Requests arriving while busy SHALL wait for IDLE.
REQ-026 uart_din SHALL be 0 whenever uart_din_vld is low.

Reset
REQ-027 While rst=1 at a clk edge, the block SHALL set the state to IDLE and clear uart_din_vld, uart_din, req_rdy, busy, grant_id and burst_cnt to 0.
REQ-028 Reset SHALL set last_grant to N_REQ-1, so requester 0 wins first.
REQ-029 A reset mid-burst SHALL abandon the held byte and SHALL NOT produce a req_rdy pulse.

Configuration
REQ-030 With macro UART_CHID_HDR_EN defined, each grant SHALL start in HDR, driving uart_din = 4'hA in the upper nibble and grant_id zero-extended in the lower nibble, held until transfer, then go to FETCH.
REQ-031 With UART_CHID_HDR_EN undefined, the HDR state and header logic SHALL be absent, and IDLE SHALL go directly to FETCH.
REQ-032 The header byte SHALL NOT count toward burst_cnt.

Structure
REQ-033 The state enum and the header marker constant 4'hA SHALL live in shared package uart_pkg.
REQ-034 The round-robin winner search SHALL be a sub-module rr_arbiter (inputs: request vector, last_grant; outputs: any, winner index).

Verification
REQ-035 Single requester: req 2 holds 3 bytes 0x11/0x22/0x33, rfd always high -> uart_din carries 0x11, 0x22, 0x33 in order; req_rdy[2] pulses 3 times; grant_id=2.
REQ-036 Fairness: all 4 requesters continuously valid, BURST_LEN=2 -> grant order 0,0,1,1,2,2,3,3,0...; no requester starved.
REQ-037 Backpressure: rfd held low 50 cycles during SEND with byte 0x5A -> uart_din_vld stays high and uart_din=0x5A throughout; exactly one transfer after rfd rises.
REQ-038 Abort: req 1 drops req_vld after its first byte -> FSM returns to IDLE; next grant goes to the lowest valid index above 1, with wrap.
REQ-039 Reset mid-SEND: rst pulsed one cycle -> next cycle all outputs are 0 and busy=0; first grant after release goes to requester 0.
REQ-040 Macro UART_CHID_HDR_EN defined, req 3 sends 0x64 -> UART bytes are 0xA3 then 0x64.
